// File: rtl/pat_pkg.sv
// pat_pkg: definitions shared by the 2^16-1 XNOR pattern checker and its
// matching generator. Polynomial x^16+x^14+x^13+x^11+1, XNOR taps.
// The generator uses the same tap constants and predictor so that both
// ends of the link stay on the same sequence.
package pat_pkg;

   // Length of the pattern shift register / history window
   localparam int PRBS_W = 16;

   // History tap positions, where H[i] holds the bit received i+1 bits ago
   localparam int TAP_A = 15;   // r[k-16]
   localparam int TAP_B = 13;   // r[k-14]
   localparam int TAP_C = 12;   // r[k-13]
   localparam int TAP_D = 10;   // r[k-11]

   // Mismatches produced by one inverted channel bit (self-synchronising
   // checker: the bad bit itself plus its four later uses as a tap)
   localparam int ERR_MULT = 5;

   // Checker acquisition / tracking state
   typedef enum logic [1:0] {
      ST_FILL   = 2'd0,   // loading the history, no compare
      ST_SEARCH = 2'd1,   // counting consecutive matches
      ST_LOCKED = 2'd2    // tracking, flagging and counting errors
   } pat_state_e;

   // Next bit of the affine recurrence given the history register
   function automatic logic prbs_predict(input logic [PRBS_W-1:0] h);
      return ~(h[TAP_A] ^ h[TAP_B] ^ h[TAP_C] ^ h[TAP_D]);
   endfunction

endpackage

// File: rtl/pat_sat_cnt.sv
// pat_sat_cnt: W-bit up counter that sticks at all-ones.
// clr has priority over inc in the same cycle; rst is synchronous,
// active-high.
module pat_sat_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: clear wins, otherwise increment until all-ones
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   // Count register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pat_chk.sv
// pat_chk: self-synchronising BER checker for the 2^16-1 XNOR pattern.
// The received stream is shifted into a 16-bit history on every EN=1
// cycle; each new bit is compared with the bit the recurrence predicts
// from that history. FILL loads 16 bits, SEARCH waits for LOCK_CNT
// consecutive matches, LOCKED flags/counts mismatches and drops back to
// SEARCH on LOSS_THRESH mismatches inside one LOSS_WIN-bit window or on
// a stuck-high (all-ones) history.
//
// Stream handshake: DIN is a qualified bit only in cycles with EN=1;
// there is no backpressure, the checker accepts every valid bit.
// LOCK, ERR and ERR_CNT reflect a sampled bit one clock later.
//
// Optional build macro PAT_CHK_BITCNT_EN adds BIT_CNT (CNT_W+8 bits),
// a saturating count of EN bits seen while LOCKED, cleared like ERR_CNT.
module pat_chk
   import pat_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int LOCK_CNT    = 32,
   parameter int LOSS_WIN    = 64,
   parameter int LOSS_THRESH = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic             DIN,
   input  logic             CLR,
   output logic             LOCK,
   output logic             ERR,
   output logic [CNT_W-1:0] ERR_CNT
`ifdef PAT_CHK_BITCNT_EN
   ,
   output logic [CNT_W+7:0] BIT_CNT
`endif
);

   localparam int FILL_W  = $clog2(PRBS_W + 1);
   localparam int MATCH_W = $clog2(LOCK_CNT + 1);
   localparam int WIN_W   = (LOSS_WIN > 1) ? $clog2(LOSS_WIN) : 1;
   localparam int WERR_W  = $clog2(LOSS_THRESH + 1);

   // Registered state
   pat_state_e          state_q,  state_d;
   logic [PRBS_W-1:0]   h_q,      h_d;
   logic [FILL_W-1:0]   fill_q,   fill_d;
   logic [MATCH_W-1:0]  match_q,  match_d;
   logic [WIN_W-1:0]    win_q,    win_d;
   logic [WERR_W-1:0]   werr_q,   werr_d;
   logic                err_q,    err_d;

   // Combinational helpers
   logic                predict;
   logic                mismatch;
   logic                h_ones;
   logic [PRBS_W-1:0]   h_shift;
   logic                h_next_ones;
   logic [WERR_W-1:0]   werr_nxt;
   logic                err_inc;

   // Prediction, mismatch and stuck-high detection for the current bit
   always_comb begin
      predict     = prbs_predict(h_q);
      mismatch    = DIN ^ predict;
      h_ones      = &h_q;
      h_shift     = {h_q[PRBS_W-2:0], DIN};
      h_next_ones = &h_shift;
      werr_nxt    = werr_q + {{(WERR_W-1){1'b0}}, mismatch};
   end

   // Next-state and counter logic; everything advances only on EN=1
   always_comb begin
      state_d = state_q;
      h_d     = h_q;
      fill_d  = fill_q;
      match_d = match_q;
      win_d   = win_q;
      werr_d  = werr_q;
      err_d   = 1'b0;
      err_inc = 1'b0;

      if (EN) begin
         h_d = h_shift;

         case (state_q)
            ST_FILL: begin
               // No compare until the history holds 16 received bits
               if (fill_q == FILL_W'(PRBS_W - 1)) begin
                  state_d = ST_SEARCH;
                  fill_d  = '0;
                  match_d = '0;
               end else begin
                  fill_d = fill_q + FILL_W'(1);
               end
            end

            ST_SEARCH: begin
               // An all-ones history also satisfies the recurrence, so
               // matches from it do not count toward lock
               if (!mismatch && !h_ones) begin
                  if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
                     state_d = ST_LOCKED;
                     match_d = '0;
                     win_d   = '0;
                     werr_d  = '0;
                  end else begin
                     match_d = match_q + MATCH_W'(1);
                  end
               end else begin
                  match_d = '0;
               end
            end

            ST_LOCKED: begin
               if (mismatch) begin
                  err_d   = 1'b1;
                  err_inc = 1'b1;
               end
               // The threshold test includes this bit's mismatch, so an
               // error on the last bit of a window still counts there
               if ((werr_nxt == WERR_W'(LOSS_THRESH)) || h_next_ones) begin
                  state_d = ST_SEARCH;
                  match_d = '0;
                  win_d   = '0;
                  werr_d  = '0;
               end else if (win_q == WIN_W'(LOSS_WIN - 1)) begin
                  win_d  = '0;
                  werr_d = '0;
               end else begin
                  win_d  = win_q + WIN_W'(1);
                  werr_d = werr_nxt;
               end
            end

            default: begin
               state_d = ST_FILL;
               fill_d  = '0;
               match_d = '0;
               win_d   = '0;
               werr_d  = '0;
            end
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_FILL;
      end else begin
         state_q <= state_d;
      end
   end

   // History, acquisition/window counters and the ERR pulse register
   always_ff @(posedge CLK) begin
      if (RST) begin
         h_q     <= '0;
         fill_q  <= '0;
         match_q <= '0;
         win_q   <= '0;
         werr_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         h_q     <= h_d;
         fill_q  <= fill_d;
         match_q <= match_d;
         win_q   <= win_d;
         werr_q  <= werr_d;
         err_q   <= err_d;
      end
   end

   assign LOCK = (state_q == ST_LOCKED);
   assign ERR  = err_q;

   // Raw mismatch count; holds across lock loss, cleared only by RST/CLR
   pat_sat_cnt #(
      .W (CNT_W)
   ) u_err_cnt (
      .clk (CLK),
      .rst (RST),
      .clr (CLR),
      .inc (err_inc),
      .cnt (ERR_CNT)
   );

`ifdef PAT_CHK_BITCNT_EN
   logic bit_inc;

   assign bit_inc = EN && (state_q == ST_LOCKED);

   // BER denominator: valid bits observed while locked
   pat_sat_cnt #(
      .W (CNT_W + 8)
   ) u_bit_cnt (
      .clk (CLK),
      .rst (RST),
      .clr (CLR),
      .inc (bit_inc),
      .cnt (BIT_CNT)
   );
`endif

endmodule

// File: tb/tb_pat_chk.sv
// tb_pat_chk: bench for pat_chk. Two instances share one stimulus stream:
// one with CNT_W=16 and one with CNT_W=4 (saturation). A bit-level model
// of the checker rules (history kept as a queue of received bits) runs on
// every clock and is compared with both instances on every cycle.
module tb_pat_chk;

   localparam int LOCK_CNT    = 32;
   localparam int LOSS_WIN    = 64;
   localparam int LOSS_THRESH = 8;

   // ---------------- clock / reset / DUT ----------------
   logic clk = 1'b0;
   logic rst, en, din, clr;
   logic        lock16, err16, lock4, err4;
   logic [15:0] cnt16;
   logic [3:0]  cnt4;
`ifdef PAT_CHK_BITCNT_EN
   logic [23:0] bits16;
   logic [11:0] bits4;
`endif

   always #5 clk = ~clk;

   pat_chk #(.CNT_W(16), .LOCK_CNT(LOCK_CNT), .LOSS_WIN(LOSS_WIN), .LOSS_THRESH(LOSS_THRESH)) dut (
      .CLK(clk), .RST(rst), .EN(en), .DIN(din), .CLR(clr),
      .LOCK(lock16), .ERR(err16), .ERR_CNT(cnt16)
`ifdef PAT_CHK_BITCNT_EN
      , .BIT_CNT(bits16)
`endif
   );

   pat_chk #(.CNT_W(4), .LOCK_CNT(LOCK_CNT), .LOSS_WIN(LOSS_WIN), .LOSS_THRESH(LOSS_THRESH)) dut_w4 (
      .CLK(clk), .RST(rst), .EN(en), .DIN(din), .CLR(clr),
      .LOCK(lock4), .ERR(err4), .ERR_CNT(cnt4)
`ifdef PAT_CHK_BITCNT_EN
      , .BIT_CNT(bits4)
`endif
   );

   // ---------------- bookkeeping ----------------
   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 40)
            $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] sat(input longint v, input int w);
      longint mx;
      mx = (longint'(1) <<< w) - 1;
      return (v > mx) ? 64'(mx) : 64'(v);
   endfunction

   // ---------------- behavioural model ----------------
   // m_rx holds the last 16 received bits, oldest first: m_rx[16-j] = r[k-j]
   int     m_phase;      // 0 fill, 1 search, 2 locked
   int     m_fill, m_match, m_wpos, m_werr;
   longint m_raw, m_bits;
   logic   m_err;
   logic   m_rx[$];
   logic   m_p, m_mis;
   bit     m_ones_before;
   bit     m_ready = 1'b0;

   function automatic bit rx_all_ones();
      foreach (m_rx[i]) if (m_rx[i] !== 1'b1) return 1'b0;
      return 1'b1;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_phase = 0; m_fill = 0; m_match = 0; m_wpos = 0; m_werr = 0;
         m_raw = 0; m_bits = 0; m_err = 1'b0;
         m_rx.delete();
         for (int i = 0; i < 16; i++) m_rx.push_back(1'b0);
         m_ready = 1'b1;
      end else if (m_ready) begin
         m_err = 1'b0;
         if (en) begin
            m_p = ~(m_rx[0] ^ m_rx[2] ^ m_rx[3] ^ m_rx[5]);
            m_mis = din ^ m_p;
            m_ones_before = rx_all_ones();
            m_rx.push_back(din);
            void'(m_rx.pop_front());
            if (m_phase == 0) begin
               m_fill++;
               if (m_fill == 16) begin m_phase = 1; m_match = 0; end
            end else if (m_phase == 1) begin
               if (!m_mis && !m_ones_before) m_match++;
               else m_match = 0;
               if (m_match == LOCK_CNT) begin m_phase = 2; m_wpos = 0; m_werr = 0; end
            end else begin
               m_bits++;
               if (m_mis) begin m_err = 1'b1; m_raw++; m_werr++; end
               m_wpos++;
               if (m_werr >= LOSS_THRESH || rx_all_ones()) begin
                  m_phase = 1; m_match = 0;
               end else if (m_wpos == LOSS_WIN) begin
                  m_wpos = 0; m_werr = 0;
               end
            end
         end
         if (clr) begin m_raw = 0; m_bits = 0; end
      end
   end

   // Every-cycle compare, away from the active edge
   always @(negedge clk) begin
      if (chk_en) begin
         check("lock",       64'(lock16), 64'(m_phase == 2));
         check("err",        64'(err16),  64'(m_err));
         check("err_cnt",    64'(cnt16),  sat(m_raw, 16));
         check("lock_w4",    64'(lock4),  64'(m_phase == 2));
         check("err_w4",     64'(err4),   64'(m_err));
         check("err_cnt_w4", 64'(cnt4),   sat(m_raw, 4));
`ifdef PAT_CHK_BITCNT_EN
         check("bit_cnt",    64'(bits16), sat(m_bits, 24));
         check("bit_cnt_w4", 64'(bits4),  sat(m_bits, 12));
`endif
      end
   end

   // ---------------- driver tasks ----------------
   logic [15:0] g;   // reference generator state, g[i] = r[k-1-i]

   task automatic drive(input logic r, input logic e, input logic d, input logic c);
      rst = r; en = e; din = d; clr = c;
      @(negedge clk);
   endtask

   task automatic send_gen(input logic flip, input logic c);
      logic b;
      b = ~(g[15] ^ g[13] ^ g[12] ^ g[10]);
      g = {g[14:0], b};
      drive(1'b0, 1'b1, b ^ flip, c);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "timeout");
   end

   // ---------------- directed tests ----------------
   logic [7:0] exp_q[$];
   int  err_seen;
   int  valid;
   bit  drop_done;

   initial begin
      rst = 1'b1; en = 1'b0; din = 1'b0; clr = 1'b0;
      @(negedge clk);

      // T1: reset state, then continuous generator stream from zero seed
      drive(1, 0, 0, 0);
      drive(1, 0, 0, 0);
      chk_en = 1'b1;
      check("rst_lock",    64'(lock16), 64'd0);
      check("rst_err",     64'(err16),  64'd0);
      check("rst_err_cnt", 64'(cnt16),  64'd0);
      g = 16'h0000;
      err_seen = 0;
      for (int i = 1; i <= 10000; i++) begin
         send_gen(1'b0, 1'b0);
         if (i == 47) check("t1_lock_bit47", 64'(lock16), 64'd0);
         if (i == 48) check("t1_lock_bit48", 64'(lock16), 64'd1);
         if (err16) err_seen++;
      end
      check("t1_err_pulses", 64'(err_seen), 64'd0);
      check("t1_err_cnt",    64'(cnt16),    64'd0);

      // T2: one inverted bit -> ERR at offsets 0,11,13,14,16
      exp_q = '{8'd0, 8'd11, 8'd13, 8'd14, 8'd16};
      for (int k = 0; k < 40; k++) begin
         send_gen(k == 0, 1'b0);
         if (err16) begin
            if (exp_q.size() > 0) check("t2_err_offset", 64'(k), 64'(exp_q.pop_front()));
            else check("t2_extra_err", 64'(k), 64'd255);
         end
      end
      check("t2_missing_err", 64'(exp_q.size()), 64'd0);
      check("t2_err_cnt",     64'(cnt16), 64'd5);
      check("t2_lock",        64'(lock16), 64'd1);

      // T3: independent random stream -> lock drops right after a mismatch
      drop_done = 1'b0;
      for (int i = 0; i < 128 && !drop_done; i++) begin
         drive(0, 1, 1'($urandom_range(0, 1)), 0);
         if (!lock16) begin
            drop_done = 1'b1;
            check("t3_drop_on_err", 64'(err16), 64'd1);
         end
      end
      check("t3_dropped", 64'(drop_done), 64'd1);
      for (int i = 0; i < 100; i++) drive(0, 1, 1'($urandom_range(0, 1)), 0);
      for (int i = 0; i < 40; i++) begin
         drive(0, 1, 1'b1, 0);
         check("t3_ones_lock", 64'(lock16), 64'd0);
      end

      // T4: reset, generator stream with ~50% EN gating
      drive(1, 0, 0, 0);
      g = 16'h0000;
      valid = 0;
      for (int c = 0; c < 1000 && valid < 48; c++) begin
         if ($urandom_range(0, 1) == 1) begin
            send_gen(1'b0, 1'b0);
            valid++;
            if (valid == 47) check("t4_lock_valid47", 64'(lock16), 64'd0);
         end else begin
            drive(0, 0, 1'($urandom_range(0, 1)), 0);
            check("t4_gap_no_lock", 64'(lock16), 64'd0);
         end
      end
      check("t4_valid_bits", 64'(valid), 64'd48);
      check("t4_lock_valid48", 64'(lock16), 64'd1);
      for (int c = 0; c < 200; c++) begin
         if ($urandom_range(0, 1) == 1) send_gen(1'b0, 1'b0);
         else drive(0, 0, 1'($urandom_range(0, 1)), 0);
      end
      check("t4_err_cnt", 64'(cnt16), 64'd0);

      // T5: 4 separated inversions -> 20 mismatches; CNT_W=4 saturates
      drive(0, 0, 0, 1);
      for (int j = 0; j < 4; j++) begin
         send_gen(1'b1, 1'b0);
         for (int k = 0; k < 99; k++) send_gen(1'b0, 1'b0);
      end
      check("t5_err_cnt16", 64'(cnt16), 64'd20);
      check("t5_err_cnt4",  64'(cnt4),  64'd15);
      check("t5_lock",      64'(lock16), 64'd1);
      send_gen(1'b1, 1'b1);  // CLR together with a mismatch
      check("t5_clr_wins16", 64'(cnt16), 64'd0);
      check("t5_clr_wins4",  64'(cnt4),  64'd0);
      check("t5_clr_err",    64'(err16), 64'd1);
      for (int k = 0; k < 20; k++) send_gen(1'b0, 1'b0);
      check("t5_tail_errs", 64'(cnt16), 64'd4);
      for (int k = 0; k < 100; k++) send_gen(1'b0, 1'b0);

      // T6: ERR_CNT=7 while locked, then reset and reacquire
      drive(0, 0, 0, 1);
      send_gen(1'b1, 1'b0);
      for (int k = 0; k < 30; k++) send_gen(1'b0, 1'b0);
      send_gen(1'b1, 1'b0);
      for (int k = 0; k < 11; k++) send_gen(1'b0, 1'b0);
      check("t6_err_cnt7", 64'(cnt16), 64'd7);
      check("t6_locked",   64'(lock16), 64'd1);
      drive(1, 0, 0, 0);
      check("t6_rst_lock",    64'(lock16), 64'd0);
      check("t6_rst_err",     64'(err16),  64'd0);
      check("t6_rst_err_cnt", 64'(cnt16),  64'd0);
      g = 16'h0000;
      for (int i = 1; i <= 48; i++) begin
         send_gen(1'b0, 1'b0);
         if (i == 47) check("t6_relock47", 64'(lock16), 64'd0);
      end
      check("t6_relock48", 64'(lock16), 64'd1);
      drive(0, 0, 0, 0);

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
